// File: rtl/cam_capture_if.sv
// Camera sensor pins plus frame-buffer write port of the cam_capture engine.
interface cam_capture_if #(
  parameter int unsigned ADDR_W = 19
);
  logic              camera_Vsync;
  logic              camera_Href;
  logic              camera_Pclk;
  logic [7:0]        camera_data;
  logic              camera_Xclk;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_data;

  modport master (
    input  camera_Vsync, camera_Href, camera_Pclk, camera_data,
    output camera_Xclk, ram_we, ram_addr, ram_data
  );

  modport slave (
    output camera_Vsync, camera_Href, camera_Pclk, camera_data,
    input  camera_Xclk, ram_we, ram_addr, ram_data
  );
endinterface

// File: rtl/cam_capture.sv
// Camera frame capture: oversamples Pclk, writes one frame to RAM, raises done.
// Optional geometry checking (frame_err) is enabled by defining CAM_GEOMETRY_CHECK_EN.
module cam_capture #(
  parameter int unsigned XCLK_DIV       = 2,
  parameter int unsigned BYTES_PER_LINE = 640,
  parameter int unsigned LINES          = 480,
  parameter int unsigned ADDR_W         = 19
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  cam_capture_if.master cam,
  output logic          busy,
  output logic          done,
  output logic          frame_err
);
  localparam int unsigned FRAME_BYTES = BYTES_PER_LINE * LINES;
  localparam int unsigned PTR_W       = ADDR_W + 1;
  localparam int unsigned CNT_MAX     = (BYTES_PER_LINE > LINES) ? BYTES_PER_LINE : LINES;
  localparam int unsigned CNT_W       = $clog2(CNT_MAX + 2);

`ifdef CAM_GEOMETRY_CHECK_EN
  localparam bit GEO_CHECK = 1'b1;
`else
  localparam bit GEO_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DONE} state_t;

  state_t            state_q, state_d;
  logic [7:0]        xcnt_q, xcnt_d;
  logic              xclk_q, xclk_d;
  logic [2:0]        vs_q, vs_d, href_q, href_d, pclk_q, pclk_d;
  logic [7:0]        data_s1_q, data_s1_d, data_s2_q, data_s2_d;
  logic              cap_q, cap_d;
  logic [7:0]        cap_data_q, cap_data_d;
  logic [PTR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d, line_cnt_q, line_cnt_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]        ram_data_q, ram_data_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic pclk_rise, vs_fall, vs_rise, href_fall, addr_full, geo_err;

  // Edge detects use the second and third synchroniser stages.
  assign pclk_rise = pclk_q[1] & ~pclk_q[2];
  assign vs_fall   = ~vs_q[1] & vs_q[2];
  assign vs_rise   = vs_q[1] & ~vs_q[2];
  assign href_fall = ~href_q[1] & href_q[2];
  assign addr_full = (addr_q >= PTR_W'(FRAME_BYTES));

  always_comb begin
    state_d    = state_q;
    xcnt_d     = xcnt_q + 8'd1;
    xclk_d     = xclk_q;
    vs_d       = {vs_q[1:0], cam.camera_Vsync};
    href_d     = {href_q[1:0], cam.camera_Href};
    pclk_d     = {pclk_q[1:0], cam.camera_Pclk};
    data_s1_d  = cam.camera_data;
    data_s2_d  = data_s1_q;
    cap_d      = 1'b0;
    cap_data_d = data_s2_q;
    addr_d     = addr_q;
    byte_cnt_d = byte_cnt_q;
    line_cnt_d = line_cnt_q;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    done_d     = done_q;
    err_d      = err_q;
    geo_err    = 1'b0;

    if (xcnt_q == 8'(XCLK_DIV - 1)) begin
      xcnt_d = 8'd0;
      xclk_d = ~xclk_q;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = WAIT_VS;
          done_d     = 1'b0;
          err_d      = 1'b0;
          addr_d     = '0;
          byte_cnt_d = '0;
          line_cnt_d = '0;
        end
      end
      WAIT_VS: begin
        if (vs_fall) state_d = CAPTURE;
      end
      CAPTURE: begin
        cap_d = pclk_rise & href_q[1];
        // Byte sampled last cycle: write it unless the frame is already full.
        if (cap_q) begin
          if (byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + CNT_W'(1);
          if (!addr_full) begin
            ram_we_d   = 1'b1;
            ram_addr_d = addr_q[ADDR_W-1:0];
            ram_data_d = cap_data_q;
            addr_d     = addr_q + PTR_W'(1);
          end else begin
            geo_err = 1'b1;
          end
        end
        if (href_fall) begin
          if (byte_cnt_d != CNT_W'(BYTES_PER_LINE)) geo_err = 1'b1;
          if (line_cnt_q != '1) line_cnt_d = line_cnt_q + CNT_W'(1);
          byte_cnt_d = '0;
        end
        if (vs_rise) begin
          if (line_cnt_d != CNT_W'(LINES)) geo_err = 1'b1;
          state_d = DONE;
          done_d  = 1'b1;
        end
        if (GEO_CHECK && geo_err) err_d = 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == WAIT_VS) || (state_d == CAPTURE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      xcnt_q     <= '0;
      xclk_q     <= 1'b0;
      vs_q       <= '0;
      href_q     <= '0;
      pclk_q     <= '0;
      data_s1_q  <= '0;
      data_s2_q  <= '0;
      cap_q      <= 1'b0;
      cap_data_q <= '0;
      addr_q     <= '0;
      byte_cnt_q <= '0;
      line_cnt_q <= '0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      xcnt_q     <= xcnt_d;
      xclk_q     <= xclk_d;
      vs_q       <= vs_d;
      href_q     <= href_d;
      pclk_q     <= pclk_d;
      data_s1_q  <= data_s1_d;
      data_s2_q  <= data_s2_d;
      cap_q      <= cap_d;
      cap_data_q <= cap_data_d;
      addr_q     <= addr_d;
      byte_cnt_q <= byte_cnt_d;
      line_cnt_q <= line_cnt_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign cam.camera_Xclk = xclk_q;
  assign cam.ram_we      = ram_we_q;
  assign cam.ram_addr    = ram_addr_q;
  assign cam.ram_data    = ram_data_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign frame_err       = err_q;
endmodule

// File: tb/tb_cam_capture.sv
// Randomised bench for cam_capture: drives a sensor model and scores RAM writes
// against a frame-level reference model.
module tb_cam_capture;
  localparam int unsigned BPL    = 4;
  localparam int unsigned LINES  = 3;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned FRAME  = BPL * LINES;

`ifdef CAM_GEOMETRY_CHECK_EN
  localparam bit GEO = 1'b1;
`else
  localparam bit GEO = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, start;
  logic busy, done, frame_err;

  cam_capture_if #(.ADDR_W(ADDR_W)) cam_bus ();

  cam_capture #(
    .XCLK_DIV(2), .BYTES_PER_LINE(BPL), .LINES(LINES), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .cam(cam_bus),
    .busy(busy), .done(done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] sent[$];
  int         lens[$];
  int         plan[$];
  logic [31:0] got_addr[$];
  logic [7:0]  got_data[$];
  logic        prev_we = 1'b0;
  bit          seq_mode;
  logic [7:0]  seq_val;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // RAM write monitor; a strobe must never follow a strobe.
  always @(negedge clk) begin
    if (cam_bus.ram_we === 1'b1) begin
      check("we_pulse", 32'(prev_we), 32'd0);
      got_addr.push_back(32'(cam_bus.ram_addr));
      got_data.push_back(cam_bus.ram_data);
    end
    prev_we = cam_bus.ram_we;
  end

  task automatic send_line(input int n);
    logic [7:0] b;
    cam_bus.camera_Href = 1'b1;
    wait_clk(4);
    for (int i = 0; i < n; i++) begin
      b = seq_mode ? seq_val : 8'($urandom);
      seq_val = seq_val + 8'd1;
      cam_bus.camera_data = b;
      sent.push_back(b);
      wait_clk(2);
      cam_bus.camera_Pclk = 1'b1;
      wait_clk(4);
      cam_bus.camera_Pclk = 1'b0;
      wait_clk(2);
    end
    wait_clk(4);
    cam_bus.camera_Href = 1'b0;
    wait_clk(8);
    lens.push_back(n);
  endtask

  task automatic send_frame();
    cam_bus.camera_Vsync = 1'b1;
    wait_clk(4);
    cam_bus.camera_Vsync = 1'b0;
    wait_clk(8);
    foreach (plan[i]) send_line(plan[i]);
    cam_bus.camera_Vsync = 1'b1;
  endtask

  task automatic do_start(input string tag);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_done_clr"}, 32'(done), 32'd0);
    got_addr.delete();
    got_data.delete();
    sent.delete();
    lens.delete();
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
  endtask

  // Reference: first FRAME bytes land at addresses 0.., surplus dropped.
  task automatic compare_frame(input string tag);
    int total, n_exp;
    bit bad;
    total = sent.size();
    n_exp = (total < int'(FRAME)) ? total : int'(FRAME);
    bad   = (lens.size() != int'(LINES)) || (total > int'(FRAME));
    foreach (lens[i]) if (lens[i] != int'(BPL)) bad = 1'b1;
    check({tag, "_nwr"}, 32'(got_addr.size()), 32'(n_exp));
    for (int i = 0; i < n_exp && i < got_addr.size(); i++) begin
      check({tag, "_addr"}, got_addr[i], 32'(i));
      check({tag, "_data"}, 32'(got_data[i]), 32'(sent[i]));
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_err"}, 32'(frame_err), 32'(GEO & bad));
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    cam_bus.camera_Vsync = 1'b1;
    cam_bus.camera_Href  = 1'b0;
    cam_bus.camera_Pclk  = 1'b0;
    cam_bus.camera_data  = 8'h00;
    seq_mode = 1'b1;
    seq_val  = 8'h10;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_xclk", 32'(cam_bus.camera_Xclk), 32'd0);
    check("rst_we", 32'(cam_bus.ram_we), 32'd0);
    check("rst_addr", 32'(cam_bus.ram_addr), 32'd0);
    check("rst_data", 32'(cam_bus.ram_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);

    // Xclk: after k edges out of reset it equals bit 1 of k
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("xclk", 32'(cam_bus.camera_Xclk), 32'((k / 2) % 2));
    end

    // Nominal frame 0x10..0x1B with a stray start mid-capture
    do_start("f1");
    plan = '{4, 4, 4};
    fork send_frame(); join_none
    for (int i = 0; i < 2000 && got_addr.size() < 2; i++) @(negedge clk);
    check("f1_pre_restart", 32'(got_addr.size()), 32'd2);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("f1_busy_hold", 32'(busy), 32'd1);
    wait fork;
    wait_done();
    // start coinciding with DONE->IDLE is ignored
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("doneidle_busy", 32'(busy), 32'd0);
    check("doneidle_done", 32'(done), 32'd1);
    compare_frame("f1");

    // Start while the sensor is mid-frame: wait for a fresh Vsync fall
    wait_clk(4);
    cam_bus.camera_Vsync = 1'b0;
    wait_clk(8);
    send_line(4);
    do_start("mid");
    send_line(4);
    cam_bus.camera_Vsync = 1'b1;
    wait_clk(8);
    check("mid_nowr", 32'(got_addr.size()), 32'd0);
    sent.delete();
    lens.delete();
    seq_mode = 1'b0;
    plan = '{4, 4, 4};
    send_frame();
    wait_done();
    compare_frame("mid");

    // Oversized line 2: 13 bytes, last one dropped
    do_start("ovf");
    plan = '{4, 5, 4};
    send_frame();
    wait_done();
    compare_frame("ovf");

    // Random geometry frames
    for (int r = 0; r < 4; r++) begin
      int nl;
      do_start("rnd");
      nl = int'($urandom_range(2, 4));
      plan.delete();
      for (int l = 0; l < nl; l++) plan.push_back(int'($urandom_range(3, 5)));
      send_frame();
      wait_done();
      compare_frame("rnd");
    end

    // Reset after 6 writes aborts the capture
    seq_mode = 1'b1;
    seq_val  = 8'h40;
    do_start("rst");
    plan = '{4, 4, 4};
    fork send_frame(); join_none
    for (int i = 0; i < 2000 && got_addr.size() < 6; i++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_we", 32'(cam_bus.ram_we), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    @(negedge clk) reset = 1'b0;
    wait fork;
    wait_clk(8);
    check("rst_mid_nwr", 32'(got_addr.size()), 32'd6);

    // Full frame after abort starts again at address 0
    do_start("post");
    plan = '{4, 4, 4};
    send_frame();
    wait_done();
    compare_frame("post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
